// File: rtl/scalar_broadcast_buffer.sv
// scalar_broadcast_buffer
//   Queues scalar operands from the core issue path. Each queued operand is
//   presented to the PE array as one element per lane. Depending on the
//   stored mode, the element is sign- or zero-extended and then either
//   replicated into every lane or placed in lane 0 only.
//
// Ports
//   clk            rising-edge clock
//   n_reset        synchronous active-low reset (priority over flush)
//   flush          synchronous clear of all queued entries
//   in_valid       scalar operand offered
//   in_ready       queue can accept (not full)
//   scalar_in      32-bit scalar operand
//   vsew           element width: 0=8b, 1=16b, 2=32b, 3=reserved (lane 0 only)
//   us             1 = zero-extend, 0 = sign-extend
//   lane0_only     1 = element in lane 0, all other lanes zero
//   out_valid      head entry present on replicated_out
//   out_ready      PE array consumes the head entry
//   replicated_out extended element per lane; lane i at [i*PE_WIDTH +: PE_WIDTH]
//   count          number of occupied entries
module scalar_broadcast_buffer #(
  parameter int NUM_PE   = 4,
  parameter int PE_WIDTH = 32,
  parameter int DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  scalar_in,
  input  logic [1:0]                   vsew,
  input  logic                         us,
  input  logic                         lane0_only,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_PE*PE_WIDTH-1:0]   replicated_out,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] scalar;
    logic [1:0]  vsew;
    logic        us;
    logic        lane0_only;
  } entry_t;

  entry_t r_mem [DEPTH];

  // Pointers carry one bit beyond the index so full and empty differ.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic [AW:0]         w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_clear;
  entry_t              w_head;
  logic [PE_WIDTH-1:0] w_elem;
  logic                w_lane0_mode;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == FULL_COUNT);
  assign w_empty = (w_count == '0);
  assign w_clear = !n_reset || flush;
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign count     = w_count;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !w_clear) begin
      r_mem[r_wr_ptr[AW-1:0]] <= '{scalar: scalar_in, vsew: vsew,
                                   us: us, lane0_only: lane0_only};
    end
  end

  assign w_head = r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_elem = w_head.scalar;
    case (w_head.vsew)
      2'd0:    w_elem = {{24{!w_head.us && w_head.scalar[7]}},  w_head.scalar[7:0]};
      2'd1:    w_elem = {{16{!w_head.us && w_head.scalar[15]}}, w_head.scalar[15:0]};
      default: w_elem = w_head.scalar;
    endcase
  end

  // The reserved width behaves like a lane-0-only move.
  assign w_lane0_mode = w_head.lane0_only || (w_head.vsew == 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign replicated_out[gi*PE_WIDTH +: PE_WIDTH] =
          out_valid ? w_elem : '0;
      end else begin : g_rest
        assign replicated_out[gi*PE_WIDTH +: PE_WIDTH] =
          (out_valid && !w_lane0_mode) ? w_elem : '0;
      end
    end
  endgenerate

endmodule

// File: doc/scalar_broadcast_buffer.md
Name: scalar_broadcast_buffer

Overview:
- Buffered, parametrised scalar-operand broadcaster for the vector accelerator.
- Accepts scalar operands from the core-side issue path into a small FIFO, together with element width, signedness and broadcast mode.
- Presents each operand, replicated and sign- or zero-extended into every PE lane, on a registered valid/ready output towards the PE array.
- Decouples scalar issue from PE back-pressure so several vector-scalar ops can be queued.

Parameters:
NUM_PE, 4, number of PE lanes in replicated_out; must be >=1.
PE_WIDTH, 32, bits per PE lane; fixed at 32, because the element-width rules below assume 32-bit lanes.
DEPTH, 2, FIFO entries; must be a power of two and >=2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
n_reset  input  1  synchronous, active-low reset.
flush  input  1  synchronous clear of the FIFO; same effect as reset, but reset has priority.
in_valid  input  1  scalar operand offered.
in_ready  output  1  FIFO can accept; equals !full.
scalar_in  input  32  scalar operand.
vsew  input  2  element width: 0=8b, 1=16b, 2=32b, 3=reserved.
us  input  1  1 = zero-extend, 0 = sign-extend.
lane0_only  input  1  1 = place element in lane 0 only, all other lanes zero (vmv.s.x style).
out_valid  output  1  replicated_out holds a valid head entry.
out_ready  input  1  PE array consumes the head entry.
replicated_out  output  NUM_PE*PE_WIDTH  extended element per lane; lane i occupies bits [i*32+31:i*32].
count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
Reset and flush
- While n_reset=0 at a clock edge: wr_ptr, rd_ptr and count go to 0; out_valid=0; in_ready=1; replicated_out reads 0.
- flush=1 at an edge has the same effect as reset. Any push or pop in that cycle is discarded.
- Reset or flush arriving mid-operation drops all queued entries. There is no partial output.

Push and pop
- Push occurs when in_valid && in_ready at an edge. The entry stores {scalar_in, vsew, us, lane0_only} at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready at an edge, and rd_ptr increments modulo DEPTH.
- Pointers wrap naturally: DEPTH is a power of two, so they carry one extra bit for full/empty.
- count tracks occupancy:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Push and pop together is legal whenever 0<count<DEPTH.
- When count==DEPTH, in_ready=0, so no push is possible. A pop in that cycle makes in_ready=1 the following cycle. in_ready does not depend combinationally on out_ready.
- When count==0 there is no pop and out_valid=0. There is no bypass: latency is one cycle from accepted input to out_valid.

Output
- out_valid = (count!=0).
- replicated_out is derived combinationally from the head entry (registered storage), so it is glitch-free with respect to the inputs.
- replicated_out and out_valid stay stable while out_valid && !out_ready.
- When out_valid=0, replicated_out = 0.

Extension rules, element e formed from the head entry:
- vsew=0: e = {24{us?0:s[7]}, s[7:0]}
- vsew=1: e = {16{us?0:s[15]}, s[15:0]}
- vsew=2: e = s[31:0]; us is ignored.
- vsew=3: e = s[31:0], placed in lane 0 only with all other lanes zero, regardless of lane0_only.

Lane placement:
- lane0_only=0: every lane = e.
- lane0_only=1: lane 0 = e, lanes 1..NUM_PE-1 = 0.

Test Plan:
1. Sign-extended broadcast. Reset, then push vsew=0, us=0, scalar 0x0000_0085, out_ready=1. Required: out_valid=1 the next cycle, all four lanes 0xFFFF_FF85, pop, count returns to 0.
2. Zero-extended 16b, mixed with lane0_only.
   - Push vsew=1, us=1, 0x1234_8001 -> all lanes 0x0000_8001.
   - Then push vsew=2, lane0_only=1, 0xDEAD_BEEF -> lane0 0xDEAD_BEEF, lanes 1-3 0.
   - vsew=3 with lane0_only=0, 0xCAFE_F00D -> lane0 0xCAFE_F00D, lanes 1-3 0.
3. Full and back-pressure. DEPTH=2, out_ready=0; push A=0x11 then B=0x22 (vsew=2).
   - Required after both: count=2, in_ready=0; a held C=0x33 is not accepted; output holds 0x11 in every lane.
   - Raise out_ready: pops return 0x11 then 0x22 in order, C is accepted once in_ready=1, wrap-around yields 0x33 third.
4. Simultaneous push and pop. With count=1, drive in_valid and out_ready together for 5 cycles with values 1..5. Required: count stays 1, outputs appear in order, no drop or duplicate.
5. Flush and reset mid-operation.
   - With count=2, assert flush for one cycle concurrent with a push: count=0, out_valid=0, in_ready=1; the pushed value never appears.
   - Repeat with n_reset=0 and flush=1 together: same result.
